// File: rtl/rom_download_packer.sv
// rom_download_packer
//
// Packs the HPS ROM download byte stream (ioctl_*) into 32-bit little-endian
// words and writes them to SDRAM through a req/ack handshake. It throttles the
// HPS with ioctl_wait while a word is pending, and reports completion (done)
// and lost words (overrun) to the core.
//
// Ports:
//   clk, reset_n     system clock, synchronous active-low reset
//   ioctl_addr       byte address of the current download byte
//   ioctl_data       download byte
//   ioctl_wr         one-cycle byte strobe
//   ioctl_download   high for the duration of a download
//   ioctl_wait       registered; high while a word is pending in SDRAM
//   sdram_addr       word address = BASE_ADDR + ioctl_addr[MSB:2]
//   sdram_data       packed word, lane n = byte address n mod 4
//   sdram_we         mirrors sdram_req
//   sdram_req        write request, held until acknowledged
//   sdram_ack        one-cycle acknowledge from the controller
//   done             download finished and every word written
//   overrun          sticky; a pending word was overwritten before its ack
module rom_download_packer #(
    parameter int unsigned IOCTL_ADDR_WIDTH = 20,
    parameter int unsigned SDRAM_ADDR_WIDTH = 23,
    parameter int unsigned BASE_ADDR        = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [IOCTL_ADDR_WIDTH-1:0] ioctl_addr,
    input  logic [7:0]                  ioctl_data,
    input  logic                        ioctl_wr,
    input  logic                        ioctl_download,
    output logic                        ioctl_wait,
    output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
    output logic [31:0]                 sdram_data,
    output logic                        sdram_we,
    output logic                        sdram_req,
    input  logic                        sdram_ack,
    output logic                        done,
    output logic                        overrun
);

    localparam int unsigned WADDR_W = IOCTL_ADDR_WIDTH - 2;

    typedef enum logic {ST_IDLE, ST_REQ} state_e;

    state_e                      state_q, state_d;
    logic [31:0]                 acc_data_q, acc_data_d;
    logic [WADDR_W-1:0]          acc_addr_q, acc_addr_d;
    logic                        acc_v_q, acc_v_d;
    logic                        defer_q, defer_d;
    logic [31:0]                 pend_data_q, pend_data_d;
    logic [SDRAM_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                        pend_v_q, pend_v_d;
    logic                        wait_q, wait_d;
    logic                        dl_q, dl_d;
    logic                        active_q, active_d;
    logic                        done_q, done_d;
    logic                        overrun_q, overrun_d;

    logic [WADDR_W-1:0]          in_waddr;
    logic [1:0]                  in_lane;
    logic                        dl_rise, dl_fall, ack_eff, flush;
    logic [31:0]                 fl_data;
    logic [WADDR_W-1:0]          fl_addr;

    // Accumulator and flush selection.
    // Only one word can enter the pending register per cycle. When two flushes
    // would coincide (discontinuity followed by a lane-3 byte, or a download
    // end right after a discontinuity), the second one is deferred by a cycle
    // through defer_q rather than overwriting the first.
    always_comb begin
        in_waddr   = ioctl_addr[IOCTL_ADDR_WIDTH-1:2];
        in_lane    = ioctl_addr[1:0];
        dl_rise    = ioctl_download & ~dl_q;
        dl_fall    = ~ioctl_download & dl_q;
        ack_eff    = sdram_ack & (state_q == ST_REQ);

        acc_data_d = acc_data_q;
        acc_addr_d = acc_addr_q;
        acc_v_d    = acc_v_q;
        defer_d    = 1'b0;
        flush      = 1'b0;
        fl_data    = '0;
        fl_addr    = '0;

        // Deferred flush or address discontinuity: old word goes out first.
        if (defer_q || (ioctl_wr && acc_v_q && (in_waddr != acc_addr_q))) begin
            flush      = 1'b1;
            fl_data    = acc_data_q;
            fl_addr    = acc_addr_q;
            acc_data_d = '0;
            acc_v_d    = 1'b0;
        end

        if (ioctl_wr) begin
            acc_data_d[{in_lane, 3'b000} +: 8] = ioctl_data;
            acc_addr_d = in_waddr;
            acc_v_d    = 1'b1;
            if (in_lane == 2'd3) begin
                if (flush) begin
                    defer_d = 1'b1;
                end else begin
                    flush      = 1'b1;
                    fl_data    = acc_data_d;
                    fl_addr    = acc_addr_d;
                    acc_data_d = '0;
                    acc_v_d    = 1'b0;
                end
            end
        end

        // Download end pushes out whatever partial word remains.
        if (dl_fall && acc_v_d && !defer_d) begin
            if (flush) begin
                defer_d = 1'b1;
            end else begin
                flush      = 1'b1;
                fl_data    = acc_data_d;
                fl_addr    = acc_addr_d;
                acc_data_d = '0;
                acc_v_d    = 1'b0;
            end
        end
    end

    // Pending register and write FSM.
    always_comb begin
        state_d     = state_q;
        pend_data_d = pend_data_q;
        pend_addr_d = pend_addr_q;
        pend_v_d    = pend_v_q;
        overrun_d   = overrun_q & ~dl_rise;

        case (state_q)
            ST_IDLE: begin
                if (flush) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_eff && !flush) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            pend_data_d = fl_data;
            pend_addr_d = SDRAM_ADDR_WIDTH'(BASE_ADDR) + SDRAM_ADDR_WIDTH'(fl_addr);
            pend_v_d    = 1'b1;
            // Overwriting an unacknowledged word loses it.
            if (pend_v_q && !ack_eff) overrun_d = 1'b1;
        end else if (ack_eff) begin
            pend_v_d = 1'b0;
        end

        wait_d = pend_v_d;
        dl_d   = ioctl_download;
    end

    // Completion tracking: active_q remembers that a download was started so
    // done only asserts after a real download, not straight out of reset.
    always_comb begin
        active_d = active_q;
        done_d   = done_q;
        if (dl_rise) begin
            done_d   = 1'b0;
            active_d = 1'b1;
        end else if (active_q && !ioctl_download && !acc_v_q && !defer_q && !pend_v_q) begin
            done_d   = 1'b1;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_data_q  <= '0;
            acc_addr_q  <= '0;
            acc_v_q     <= 1'b0;
            defer_q     <= 1'b0;
            pend_data_q <= '0;
            pend_addr_q <= '0;
            pend_v_q    <= 1'b0;
            wait_q      <= 1'b0;
            dl_q        <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_data_q  <= acc_data_d;
            acc_addr_q  <= acc_addr_d;
            acc_v_q     <= acc_v_d;
            defer_q     <= defer_d;
            pend_data_q <= pend_data_d;
            pend_addr_q <= pend_addr_d;
            pend_v_q    <= pend_v_d;
            wait_q      <= wait_d;
            dl_q        <= dl_d;
            active_q    <= active_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sdram_req  = (state_q == ST_REQ);
    assign sdram_we   = sdram_req;
    assign sdram_addr = pend_v_q ? pend_addr_q : '0;
    assign sdram_data = pend_v_q ? pend_data_q : '0;
    assign ioctl_wait = wait_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

endmodule
